// File: rtl/ifetch_align_pkg.sv
// Shared types and constants for the instruction-fetch aligner.
package ifetch_align_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    MISSWAIT = 2'd1,
    DISCARD  = 2'd2,
    REHINT   = 2'd3
  } fstate_t;

  localparam logic [2:0]  OFF7       = 3'b111;
  localparam logic [31:0] INST_NOP_C = 32'h0000_0001;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_c;
  } fq_entry_t;

  function automatic logic is_rvc(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction

endpackage

// File: rtl/ifetch_align_queue.sv
// Two-entry instruction buffer between fetch and decode, flushable.
module ifetch_queue
  import ifetch_align_pkg::*;
(
  input  logic       clk,
  input  logic       proc_reset,
  input  logic       flush,
  input  logic       push,
  input  fq_entry_t  push_data,
  input  logic       pop_ready,
  output logic       head_valid,
  output fq_entry_t  head,
  output logic [1:0] count
);

  fq_entry_t mem [2];
  logic      rd_ptr;
  logic      wr_ptr;
  logic      pop;

  assign head_valid = count != 2'd0;
  assign head       = mem[rd_ptr];
  assign pop        = head_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/ifetch_align.sv
// Fetch front end: owns the PC, sizes RVC/32-bit instructions,
// drives the cache length hint and handles redirects across misses.
module ifetch_align
  import ifetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        proc_reset,
  output logic        icache_read,
  output logic [31:0] icache_addr,
  output logic        icache_next_inst_32,
  input  logic [31:0] icache_rdata,
  input  logic        icache_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_c
);

  fstate_t     state, n_state;
  logic [31:0] pc, n_pc;
  logic [31:0] tgt, n_tgt;
  logic        hint, n_hint;
  logic        known, n_known;
  logic        dhint, n_dhint;
  logic        hint_o;
  logic        rd;
  logic        resp;
  logic        take;
  logic        flush;
  logic        is32;
  logic        off7;
  logic        upper;
  logic [31:0] step;
  logic        q_valid;
  logic [1:0]  q_count;
  fq_entry_t   q_head;
  fq_entry_t   q_in;
  logic        unused_ok;

  assign unused_ok = redirect_pc[0];

  assign is32  = !is_rvc(icache_rdata[1:0]);
  assign off7  = (pc[3:1] == OFF7) && !known;
  assign upper = (pc[3:1] != OFF7) || hint_o;
  assign step  = is32 ? 32'd4 : 32'd2;
  assign resp  = icache_read && !icache_stall;

  // DISCARD replays the hint that went out with the abandoned miss
  always_comb begin
    hint_o = 1'b0;
    unique case (1'b1)
      state == DISCARD: hint_o = dhint;
      state == REHINT:  hint_o = 1'b1;
      default:          hint_o = hint && known;
    endcase
  end

  always_comb begin
    rd = 1'b1;
    if (state == FETCH)
      rd = (int'(q_count) < QDEPTH) || inst_ready;
  end

  assign icache_read         = rd && !proc_reset;
  assign icache_addr         = pc;
  assign icache_next_inst_32 = hint_o && !proc_reset;

  assign q_in = '{
    pc:   pc,
    inst: is32 ? icache_rdata : {16'd0, icache_rdata[15:0]},
    is_c: !is32
  };

  always_comb begin
    n_state = state;
    n_pc    = pc;
    n_tgt   = tgt;
    n_hint  = hint;
    n_known = known;
    n_dhint = dhint;
    take    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      n_tgt = {redirect_pc[31:1], 1'b0};
      if (icache_read && icache_stall) begin
        n_state = DISCARD;
        if (state != DISCARD) n_dhint = hint_o;
      end else begin
        n_state = FETCH;
        n_pc    = {redirect_pc[31:1], 1'b0};
        n_known = 1'b0;
      end
    end else begin
      unique case (state)
        FETCH, MISSWAIT: begin
          n_state = FETCH;
          if (icache_read && icache_stall)
            n_state = MISSWAIT;
          else if (resp && off7 && is32)
            n_state = REHINT;
          else
            take = resp;
        end
        REHINT: begin
          if (resp) begin
            n_state = FETCH;
            take    = 1'b1;
          end
        end
        DISCARD: begin
          if (!icache_stall) begin
            n_state = FETCH;
            n_pc    = tgt;
            n_known = 1'b0;
          end
        end
      endcase
      if (take) begin
        n_pc = pc + step;
        if (is32 || !upper) begin
          n_known = 1'b0;
        end else begin
          n_hint  = icache_rdata[17:16] == 2'b11;
          n_known = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= FETCH;
      pc    <= {RESET_PC[31:1], 1'b0};
      tgt   <= {RESET_PC[31:1], 1'b0};
      hint  <= 1'b0;
      known <= 1'b1;
      dhint <= 1'b0;
    end else begin
      state <= n_state;
      pc    <= n_pc;
      tgt   <= n_tgt;
      hint  <= n_hint;
      known <= n_known;
      dhint <= n_dhint;
    end
  end

  ifetch_queue u_queue (
    .clk        (clk),
    .proc_reset (proc_reset),
    .flush      (flush),
    .push       (take),
    .push_data  (q_in),
    .pop_ready  (inst_ready),
    .head_valid (q_valid),
    .head       (q_head),
    .count      (q_count)
  );

  assign inst_valid = q_valid;
  assign inst       = q_head.inst;
  assign inst_pc    = q_head.pc;
  assign inst_is_c  = q_head.is_c;

endmodule

// File: tb/tb_ifetch_align.sv
// Bench for ifetch_align: directed scenarios, then random traffic checked
// against an in-order walk of the program image.
module tb_ifetch_align;

  logic        clk = 1'b0;
  logic        proc_reset;
  logic        icache_read;
  logic [31:0] icache_addr;
  logic        icache_next_inst_32;
  logic [31:0] icache_rdata;
  logic        icache_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_c;

  ifetch_align #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk                 (clk),
    .proc_reset          (proc_reset),
    .icache_read         (icache_read),
    .icache_addr         (icache_addr),
    .icache_next_inst_32 (icache_next_inst_32),
    .icache_rdata        (icache_rdata),
    .icache_stall        (icache_stall),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .inst_valid          (inst_valid),
    .inst_ready          (inst_ready),
    .inst                (inst),
    .inst_pc             (inst_pc),
    .inst_is_c           (inst_is_c)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:1023];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  int          miss_left;
  int          miss_len;
  int          idle;
  bit          rand_miss;
  logic [31:0] miss_at;
  logic        prev_stall;
  logic        prev_redir;
  logic        prev_hint;
  logic [31:0] prev_addr;
  logic [31:0] a3;
  logic [31:0] p3;

  function automatic logic [15:0] hw(input logic [31:0] a);
    return mem[a[10:1]];
  endfunction

  // cache: upper half absent on a line-crossing fetch without the hint
  always_comb begin
    if (icache_stall)
      icache_rdata = 32'hFFFF_FFFF;
    else if (icache_addr[3:1] == 3'b111 && !icache_next_inst_32)
      icache_rdata = {16'hFFFF, hw(icache_addr)};
    else
      icache_rdata = {hw(icache_addr + 32'd2), hw(icache_addr)};
  end

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prep();
    #1;
    if (proc_reset || !icache_read) begin
      icache_stall = 1'b0;
    end else begin
      if (!prev_stall) begin
        if (icache_addr == miss_at)
          miss_left = miss_len;
        else if (rand_miss && $urandom_range(0, 3) == 0)
          miss_left = $urandom_range(1, 5);
        else
          miss_left = 0;
      end
      icache_stall = miss_left != 0;
    end
    #1;
  endtask

  task automatic fin();
    logic [15:0] lo;
    logic [15:0] hl;
    logic [31:0] e_inst;
    logic        e_c;
    logic [31:0] e_step;
    if (!proc_reset) begin
      if (prev_stall)
        chk("stall_hold",
            {icache_read, icache_next_inst_32, icache_addr},
            {1'b1, prev_hint, prev_addr});
      if (prev_redir) chk("flush_valid", inst_valid, 0);
      if (icache_read) chk("addr_even", icache_addr[0], 0);
      if (icache_read && icache_next_inst_32) begin
        hl = hw(icache_addr);
        chk("hint_true", hl[1:0], 2'b11);
      end
      chk("liveness", idle < 60, 1);
      if (inst_valid && inst_ready && !redirect_valid) begin
        lo = hw(exp_pc);
        if (lo[1:0] == 2'b11) begin
          e_inst = {hw(exp_pc + 32'd2), lo};
          e_c    = 1'b0;
          e_step = 32'd4;
        end else begin
          e_inst = {16'd0, lo};
          e_c    = 1'b1;
          e_step = 32'd2;
        end
        chk("head", {inst_pc, inst, inst_is_c}, {exp_pc, e_inst, e_c});
        exp_pc = exp_pc + e_step;
        idle   = 0;
      end else begin
        idle++;
      end
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:1], 1'b0};
        idle   = 0;
      end
    end else begin
      exp_pc = 32'h0;
      idle   = 0;
    end
    prev_stall = !proc_reset && icache_read && icache_stall;
    prev_redir = !proc_reset && redirect_valid;
    prev_addr  = icache_addr;
    prev_hint  = icache_next_inst_32;
    if (icache_stall) miss_left--;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    prep();
    fin();
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    proc_reset     = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    icache_stall   = 1'b0;
    prev_stall     = 1'b0;
    prev_redir     = 1'b0;
    prev_hint      = 1'b0;
    prev_addr      = 32'h0;
    miss_at        = 32'h1;
    miss_len       = 0;
    miss_left      = 0;
    rand_miss      = 1'b0;
    idle           = 0;
    exp_pc         = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) mem[i][1:0] = 2'b11;
    end
    mem[0]   = 16'h0093; mem[1]   = 16'h00A0;
    mem[2]   = 16'h0113; mem[3]   = 16'h00B0;
    mem[8]   = 16'h4505; mem[9]   = 16'h4501;
    mem[15]  = 16'h0513; mem[16]  = 16'h0000;
    mem[32]  = 16'h0093; mem[33]  = 16'h0010;
    mem[128] = 16'h0113; mem[129] = 16'h0020;

    @(posedge clk);
    #1;
    // reset: every output low
    for (int i = 0; i < 2; i++) begin
      prep();
      chk("rst_read", icache_read, 0);
      chk("rst_addr", icache_addr, 0);
      chk("rst_hint", icache_next_inst_32, 0);
      chk("rst_head", {inst_valid, inst, inst_pc, inst_is_c}, 0);
      fin();
    end
    proc_reset = 1'b0;

    // two 32-bit hits from RESET_PC
    prep();
    chk("a_read1", icache_read, 1);
    chk("a_valid1", inst_valid, 0);
    fin();
    prep();
    chk("a_valid2", {inst_valid, inst_pc, icache_addr}, {1'b1, 32'h0, 32'h4});
    fin();
    prep();
    chk("a_pc3", {icache_read, inst_pc}, {1'b1, 32'h4});
    fin();

    // two RVC halves from one word
    redir(32'h11);
    prep();
    chk("b_addr", {icache_addr, inst_valid}, {32'h10, 1'b0});
    fin();
    prep();
    chk("b_c0", {inst_pc, inst, inst_is_c, icache_addr},
        {32'h10, 32'h4505, 1'b1, 32'h12});
    fin();
    prep();
    chk("b_c1", {inst_pc, inst, inst_is_c, icache_addr},
        {32'h12, 32'h4501, 1'b1, 32'h14});
    fin();

    // offset-7 refetch
    redir(32'h1E);
    prep();
    chk("c_first", {icache_addr, icache_next_inst_32}, {32'h1E, 1'b0});
    fin();
    prep();
    chk("c_rehint", {icache_addr, icache_next_inst_32, inst_valid},
        {32'h1E, 1'b1, 1'b0});
    fin();
    prep();
    chk("c_push", {inst_valid, inst_pc, inst, inst_is_c},
        {1'b1, 32'h1E, 32'h0000_0513, 1'b0});
    fin();

    // five-cycle miss at 0x40
    redir(32'h40);
    miss_at  = 32'h40;
    miss_len = 5;
    for (int i = 0; i < 5; i++) begin
      prep();
      chk("d_hold", {icache_read, icache_stall, icache_addr, inst_valid},
          {1'b1, 1'b1, 32'h40, 1'b0});
      fin();
    end
    prep();
    chk("d_drop", {icache_stall, icache_addr, inst_valid}, {1'b0, 32'h40, 1'b0});
    fin();
    prep();
    chk("d_push", {inst_valid, inst_pc, icache_addr}, {1'b1, 32'h40, 32'h44});
    fin();
    miss_at = 32'h1;

    // redirect to 0x100 while the 0x40 miss is outstanding
    redir(32'h40);
    miss_at = 32'h40;
    prep();
    chk("e_miss", {icache_stall, icache_addr}, {1'b1, 32'h40});
    fin();
    redir(32'h100);
    for (int i = 0; i < 3; i++) begin
      prep();
      chk("e_hold", {icache_read, icache_addr}, {1'b1, 32'h40});
      fin();
    end
    prep();
    chk("e_drop", {icache_stall, icache_addr, inst_valid}, {1'b0, 32'h40, 1'b0});
    fin();
    prep();
    chk("e_new", {icache_addr, inst_valid}, {32'h100, 1'b0});
    fin();
    prep();
    chk("e_push", {inst_valid, inst_pc}, {1'b1, 32'h100});
    fin();
    miss_at = 32'h1;

    // backpressure: queue fills, fetch stops, pc frozen
    inst_ready = 1'b0;
    cyc();
    cyc();
    prep();
    chk("f_read3", {icache_read, inst_valid}, {1'b0, 1'b1});
    a3 = icache_addr;
    p3 = inst_pc;
    fin();
    prep();
    chk("f_read4", icache_read, 0);
    chk("f_frozen", {icache_addr, inst_pc}, {a3, p3});
    fin();
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();

    // random misses, backpressure, redirects and resets
    rand_miss = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      inst_ready     = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 29) == 0;
      redirect_pc    = $urandom_range(0, 2047);
      proc_reset     = $urandom_range(0, 499) == 0;
      cyc();
    end
    proc_reset     = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    rand_miss      = 1'b0;
    for (int i = 0; i < 20; i++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
